// File: rtl/word_byte_serializer.sv
// -----------------------------------------------------------------------------
// word_byte_serializer
//
// Accepts WORD_W-bit words over a valid/ready handshake and emits each word as
// N = WORD_W/SLICE_W slices over a second valid/ready handshake. One word is
// buffered internally. The next word can be accepted on the same cycle that
// the final slice of the current word is taken, so back-to-back words stream
// without bubbles.
//
// Parameters
//   WORD_W     input word width
//   SLICE_W    output slice width (WORD_W must be a multiple of SLICE_W)
//   MSB_FIRST  1: most-significant slice first, 0: least-significant first
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_word    word to serialize
//   in_valid   in_word is valid
//   in_ready   block can accept a word this cycle
//   out_slice  current slice
//   out_idx    index of the slice within the word (0..N-1)
//   out_last   out_slice is the final slice of the word
//   out_valid  out_slice/out_idx/out_last are valid
//   out_ready  downstream accepts the slice this cycle
//   busy       a word is held
// -----------------------------------------------------------------------------
module word_byte_serializer #(
  parameter  int WORD_W    = 32,
  parameter  int SLICE_W   = 8,
  parameter  int MSB_FIRST = 1,
  localparam int N         = WORD_W / SLICE_W,
  localparam int IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WORD_W-1:0]  in_word,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [SLICE_W-1:0] out_slice,
  output logic [IDX_W-1:0]   out_idx,
  output logic               out_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               busy
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t              state, next_state;
  logic [WORD_W-1:0]   buffer, next_buffer;
  logic [IDX_W-1:0]    idx, next_idx;
  logic [IDX_W-1:0]    sel;
  logic [SLICE_W-1:0]  slices [N];
  logic                sending;
  logic                at_last;

  // Break the held word into an array of slices, slice 0 in the low bits.
  for (genvar g = 0; g < N; g++) begin : g_slices
    assign slices[g] = buffer[g*SLICE_W +: SLICE_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      buffer <= '0;
      idx    <= '0;
    end else begin
      state  <= next_state;
      buffer <= next_buffer;
      idx    <= next_idx;
    end
  end

  always_comb begin
    next_state  = state;
    next_buffer = buffer;
    next_idx    = idx;

    sending = (state == SEND);
    at_last = sending && (idx == LAST_IDX);
    sel     = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;

    // Outputs are forced to zero outside SEND so that reset and idle
    // present a clean, all-zero slice interface.
    out_valid = sending;
    busy      = sending;
    out_last  = at_last;
    out_idx   = sending ? idx : '0;
    out_slice = sending ? slices[sel] : '0;

    // A new word may enter while the final slice is leaving; this is the
    // only path from an input (out_ready) to an output.
    in_ready  = (state == IDLE) || (at_last && out_ready);

    case (state)
      IDLE: begin
        if (in_valid) begin
          next_buffer = in_word;
          next_idx    = '0;
          next_state  = SEND;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (!at_last) begin
            next_idx = idx + IDX_W'(1);
          end else if (in_valid) begin
            next_buffer = in_word;
            next_idx    = '0;
          end else begin
            next_idx   = '0;
            next_state = IDLE;
          end
        end
      end
      default: begin
        next_state = IDLE;
        next_idx   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
module tb_word_byte_serializer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] in_word;
  logic        in_valid;
  logic        out_ready;

  logic        a_in_ready, a_last, a_valid, a_busy;
  logic [7:0]  a_slice;
  logic [1:0]  a_idx;

  logic        b_in_ready, b_last, b_valid, b_busy;
  logic [7:0]  b_slice;
  logic [1:0]  b_idx;

  logic        c_in_ready, c_last, c_valid, c_busy;
  logic [7:0]  c_slice;
  logic [0:0]  c_idx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  word_byte_serializer #(.WORD_W(32), .SLICE_W(8), .MSB_FIRST(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(a_in_ready), .out_slice(a_slice), .out_idx(a_idx),
    .out_last(a_last), .out_valid(a_valid), .out_ready(out_ready), .busy(a_busy)
  );

  word_byte_serializer #(.WORD_W(32), .SLICE_W(8), .MSB_FIRST(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_word(in_word), .in_valid(in_valid),
    .in_ready(b_in_ready), .out_slice(b_slice), .out_idx(b_idx),
    .out_last(b_last), .out_valid(b_valid), .out_ready(out_ready), .busy(b_busy)
  );

  // Single-slice configuration (N == 1)
  word_byte_serializer #(.WORD_W(8), .SLICE_W(8), .MSB_FIRST(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_word(in_word[7:0]), .in_valid(in_valid),
    .in_ready(c_in_ready), .out_slice(c_slice), .out_idx(c_idx),
    .out_last(c_last), .out_valid(c_valid), .out_ready(out_ready), .busy(c_busy)
  );

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks the full output set of instance A (sel=0) or B (sel=1).
  task automatic checkOutput(input string tag, input bit sel, input logic v,
                             input logic [7:0] s, input logic [1:0] i,
                             input logic l, input logic r);
    if (!sel) begin
      checkVal({tag, " a.valid"},    32'(a_valid),    32'(v));
      checkVal({tag, " a.busy"},     32'(a_busy),     32'(v));
      checkVal({tag, " a.slice"},    32'(a_slice),    32'(s));
      checkVal({tag, " a.idx"},      32'(a_idx),      32'(i));
      checkVal({tag, " a.last"},     32'(a_last),     32'(l));
      checkVal({tag, " a.in_ready"}, 32'(a_in_ready), 32'(r));
    end else begin
      checkVal({tag, " b.valid"},    32'(b_valid),    32'(v));
      checkVal({tag, " b.busy"},     32'(b_busy),     32'(v));
      checkVal({tag, " b.slice"},    32'(b_slice),    32'(s));
      checkVal({tag, " b.idx"},      32'(b_idx),      32'(i));
      checkVal({tag, " b.last"},     32'(b_last),     32'(l));
      checkVal({tag, " b.in_ready"}, 32'(b_in_ready), 32'(r));
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] w, input logic r);
    in_valid  = v;
    in_word   = w;
    out_ready = r;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b0);
    #12;
    checkVal("reset a.valid", 32'(a_valid), 32'd0);
    checkVal("reset a.slice", 32'(a_slice), 32'd0);
    checkVal("reset a.idx",   32'(a_idx),   32'd0);
    checkVal("reset a.last",  32'(a_last),  32'd0);
    checkVal("reset a.busy",  32'(a_busy),  32'd0);
    rst_n = 1'b1;

    // Test 1: MSB-first, 0x12345678
    nextCycle();
    applyStimulus(1'b1, 32'h12345678, 1'b1);
    checkOutput("t1 idle", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'hFFFFFFFF, 1'b1);
    checkOutput("t1 s0", 1'b0, 1'b1, 8'h12, 2'd0, 1'b0, 1'b0);
    checkVal("t1 c.valid",    32'(c_valid),    32'd1);
    checkVal("t1 c.slice",    32'(c_slice),    32'h78);
    checkVal("t1 c.idx",      32'(c_idx),      32'd0);
    checkVal("t1 c.last",     32'(c_last),     32'd1);
    checkVal("t1 c.in_ready", 32'(c_in_ready), 32'd1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t1 s1", 1'b0, 1'b1, 8'h34, 2'd1, 1'b0, 1'b0);
    checkVal("t1 c.idle", 32'(c_valid), 32'd0);
    nextCycle();
    checkOutput("t1 s2", 1'b0, 1'b1, 8'h56, 2'd2, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t1 s3", 1'b0, 1'b1, 8'h78, 2'd3, 1'b1, 1'b1);
    nextCycle();
    checkOutput("t1 end", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Test 2: LSB-first instance, 0xA1B2C3D4
    applyStimulus(1'b1, 32'hA1B2C3D4, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t2 s0", 1'b1, 1'b1, 8'hD4, 2'd0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t2 s1", 1'b1, 1'b1, 8'hC3, 2'd1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t2 s2", 1'b1, 1'b1, 8'hB2, 2'd2, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t2 s3", 1'b1, 1'b1, 8'hA1, 2'd3, 1'b1, 1'b1);
    nextCycle();
    checkOutput("t2 end", 1'b1, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Test 3: backpressure on slice 1 of 0xDEADBEEF
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3 s0", 1'b0, 1'b1, 8'hDE, 2'd0, 1'b0, 1'b0);
    nextCycle();
    applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0);
    checkOutput("t3 stall0", 1'b0, 1'b1, 8'hAD, 2'd1, 1'b0, 1'b0);
    for (int k = 1; k < 3; k++) begin
      nextCycle();
      applyStimulus(1'b1, 32'hFFFFFFFF, 1'b0);
      checkOutput($sformatf("t3 stall%0d", k), 1'b0, 1'b1, 8'hAD, 2'd1, 1'b0, 1'b0);
    end
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t3 release", 1'b0, 1'b1, 8'hAD, 2'd1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t3 s2", 1'b0, 1'b1, 8'hBE, 2'd2, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t3 s3", 1'b0, 1'b1, 8'hEF, 2'd3, 1'b1, 1'b1);
    nextCycle();
    checkOutput("t3 end", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Test 4: back-to-back words
    applyStimulus(1'b1, 32'h01020304, 1'b1);
    nextCycle();
    applyStimulus(1'b1, 32'h05060708, 1'b1);
    checkOutput("t4 s0", 1'b0, 1'b1, 8'h01, 2'd0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t4 s1", 1'b0, 1'b1, 8'h02, 2'd1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t4 s2", 1'b0, 1'b1, 8'h03, 2'd2, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t4 s3", 1'b0, 1'b1, 8'h04, 2'd3, 1'b1, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t4 s4", 1'b0, 1'b1, 8'h05, 2'd0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t4 s5", 1'b0, 1'b1, 8'h06, 2'd1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t4 s6", 1'b0, 1'b1, 8'h07, 2'd2, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t4 s7", 1'b0, 1'b1, 8'h08, 2'd3, 1'b1, 1'b1);
    nextCycle();
    checkOutput("t4 end", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Test 5: reset in the middle of 0xCAFEF00D
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t5 s0", 1'b0, 1'b1, 8'hCA, 2'd0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t5 s1", 1'b0, 1'b1, 8'hFE, 2'd1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t5 s2", 1'b0, 1'b1, 8'hF0, 2'd2, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkVal("t5 rst a.valid", 32'(a_valid), 32'd0);
    checkVal("t5 rst a.slice", 32'(a_slice), 32'd0);
    checkVal("t5 rst a.idx",   32'(a_idx),   32'd0);
    checkVal("t5 rst a.last",  32'(a_last),  32'd0);
    checkVal("t5 rst a.busy",  32'(a_busy),  32'd0);
    #2;
    rst_n = 1'b1;
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t5 after", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 32'h11223344, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("t5 n0", 1'b0, 1'b1, 8'h11, 2'd0, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t5 n1", 1'b0, 1'b1, 8'h22, 2'd1, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t5 n2", 1'b0, 1'b1, 8'h33, 2'd2, 1'b0, 1'b0);
    nextCycle();
    checkOutput("t5 n3", 1'b0, 1'b1, 8'h44, 2'd3, 1'b1, 1'b1);
    nextCycle();
    checkOutput("t5 end", 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1);

    // Test 6: idle for 20 cycles after reset
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      nextCycle();
      applyStimulus(1'b0, $urandom, 1'b1);
      checkVal($sformatf("t6 c%0d valid", k),    32'(a_valid),    32'd0);
      checkVal($sformatf("t6 c%0d busy", k),     32'(a_busy),     32'd0);
      checkVal($sformatf("t6 c%0d in_ready", k), 32'(a_in_ready), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
